// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for reg_file and the blocks that write into it.
//   DefaultDataWidth   default width of one register / write data word
//   DefaultNumRegs     default number of registers in reg_file
//   indexWidth(n)      address width needed to select one of n registers
//   regIdx_t           register index type for the default configuration
// ---------------------------------------------------------------------------
package reg_file_pkg;

  localparam int DefaultDataWidth = 32;
  localparam int DefaultNumRegs   = 4;

  // A single-register file still needs a one-bit address so port widths never collapse to zero.
  function automatic int indexWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DefaultIndexWidth = (DefaultNumRegs > 1) ? $clog2(DefaultNumRegs) : 1;

  typedef logic [DefaultIndexWidth-1:0] regIdx_t;

endpackage

// File: rtl/rr_priority_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Rotating-priority selector: picks the first set request bit starting at
// position ptr and wrapping around the vector.
//   req     in   NumReq      request vector (already masked by any blocking condition)
//   ptr     in   IdWidth     position with the highest priority this cycle
//   grant   out  NumReq      one-hot grant, all zero when no request is set
//   idx     out  IdWidth     encoded position of the granted bit (0 when none)
//   any     out  1           at least one request was granted
// ---------------------------------------------------------------------------
module rr_priority_picker #(
  parameter int NumReq  = 2,
  parameter int IdWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdWidth-1:0] ptr,
  output logic [NumReq-1:0]  grant,
  output logic [IdWidth-1:0] idx,
  output logic               any
);

  // Walk the candidates in priority order ptr, ptr+1, ... and stop at the
  // first one that is requesting; the found flag keeps the result one-hot.
  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NumReq; k++) begin
      cand = (int'(ptr) + k) % NumReq;
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = IdWidth'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_file_wr_arbiter.sv
// ---------------------------------------------------------------------------
// reg_file_wr_arbiter
// Shares the single write port of reg_file between NumReq requesters using
// round-robin arbitration, a valid/ready handshake per requester and a
// registered write stage that drives reg_file directly.
//   clk        in   1                   clock, rising edge
//   rst        in   1                   synchronous active-high reset
//   reqValid   in   NumReq              requester i has a write pending
//   reqReady   out  NumReq              one-hot grant (accept = valid & ready)
//   reqAddr    in   NumReq*IndexWidth   requester i address, slice i
//   reqData    in   NumReq*DataWidth    requester i data, slice i
//   stall      in   1                   blocks all new grants
//   writeEn    out  1                   registered write strobe
//   writeAddr  out  IndexWidth          registered write address
//   writeData  out  DataWidth           registered write data
//   grantId    out  ReqIdWidth          requester owning the current write
// Build option: REG_FILE_WR_ZERO_PROTECT_EN -- writes to register 0 are still
// accepted but never strobed into reg_file.
// ---------------------------------------------------------------------------
module reg_file_wr_arbiter
  import reg_file_pkg::*;
#(
  parameter int DataWidth  = DefaultDataWidth,
  parameter int NumRegs    = DefaultNumRegs,
  parameter int IndexWidth = indexWidth(NumRegs),
  parameter int NumReq     = 2,
  parameter int ReqIdWidth = $clog2(NumReq)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NumReq-1:0]            reqValid,
  output logic [NumReq-1:0]            reqReady,
  input  logic [NumReq*IndexWidth-1:0] reqAddr,
  input  logic [NumReq*DataWidth-1:0]  reqData,
  input  logic                         stall,
  output logic                         writeEn,
  output logic [IndexWidth-1:0]        writeAddr,
  output logic [DataWidth-1:0]         writeData,
  output logic [ReqIdWidth-1:0]        grantId
);

  logic [ReqIdWidth-1:0] r_ptr;
  logic                  r_writeEn;
  logic [IndexWidth-1:0] r_writeAddr;
  logic [DataWidth-1:0]  r_writeData;
  logic [ReqIdWidth-1:0] r_grantId;

  logic [NumReq-1:0]     w_eligible;
  logic [NumReq-1:0]     w_grant;
  logic [ReqIdWidth-1:0] w_grantIdx;
  logic                  w_accept;
  logic [ReqIdWidth-1:0] w_ptrNext;
  logic [IndexWidth-1:0] w_selAddr;
  logic [DataWidth-1:0]  w_selData;
  logic                  w_writeAllowed;

  // Reset and stall both hide every request from the picker, so no ready is raised.
  assign w_eligible = (rst || stall) ? '0 : reqValid;

  rr_priority_picker #(
    .NumReq  (NumReq),
    .IdWidth (ReqIdWidth)
  ) u_picker (
    .req   (w_eligible),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_grantIdx),
    .any   (w_accept)
  );

  assign reqReady = w_grant;

  // Pointer moves just past the winner, wrapping explicitly for non power-of-two NumReq.
  assign w_ptrNext = (w_grantIdx == ReqIdWidth'(NumReq - 1)) ? '0 : w_grantIdx + ReqIdWidth'(1);

  // Route the winning requester's address and data toward the write stage.
  always_comb begin
    w_selAddr = '0;
    w_selData = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (w_grant[i]) begin
        w_selAddr = reqAddr[i*IndexWidth +: IndexWidth];
        w_selData = reqData[i*DataWidth +: DataWidth];
      end
    end
  end

`ifdef REG_FILE_WR_ZERO_PROTECT_EN
  // Register 0 is read-only from this port: the handshake completes but no strobe is issued.
  assign w_writeAllowed = (w_selAddr != '0);
`else
  assign w_writeAllowed = 1'b1;
`endif

  // Write stage and round-robin pointer; address, data and id hold when nothing is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_writeEn   <= 1'b0;
      r_writeAddr <= '0;
      r_writeData <= '0;
      r_grantId   <= '0;
    end else begin
      r_writeEn <= w_accept & w_writeAllowed;
      if (w_accept) begin
        r_ptr       <= w_ptrNext;
        r_writeAddr <= w_selAddr;
        r_writeData <= w_selData;
        r_grantId   <= w_grantIdx;
      end
    end
  end

  assign writeEn   = r_writeEn;
  assign writeAddr = r_writeAddr;
  assign writeData = r_writeData;
  assign grantId   = r_grantId;

endmodule

// File: tb/tb_reg_file_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_file_wr_arbiter
// Self-checking bench for reg_file_wr_arbiter (2 requesters, 4 x 32-bit regs).
// Directed scenarios with literal expectations, then randomized traffic with
// resets and stalls, all cross-checked every cycle against a behavioural
// model of the arbiter and of the reg_file contents.
// ---------------------------------------------------------------------------
module tb_reg_file_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 2;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     reqValid;
  logic [NR-1:0]     reqReady;
  logic [NR*IW-1:0]  reqAddr;
  logic [NR*DW-1:0]  reqData;
  logic              stall;
  logic              writeEn;
  logic [IW-1:0]     writeAddr;
  logic [DW-1:0]     writeData;
  logic              grantId;

  int total = 0;
  int bad   = 0;

  reg_file_wr_arbiter #(
    .DataWidth (DW),
    .NumRegs   (4),
    .NumReq    (NR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqReady  (reqReady),
    .reqAddr   (reqAddr),
    .reqData   (reqData),
    .stall     (stall),
    .writeEn   (writeEn),
    .writeAddr (writeAddr),
    .writeData (writeData),
    .grantId   (grantId)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it and reports a FAIL line on any difference (X included).
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives the complete input set; called just after a rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic [1:0] v,
                               input logic [1:0] a0, input logic [31:0] d0,
                               input logic [1:0] a1, input logic [31:0] d1);
    rst      = r;
    stall    = s;
    reqValid = v;
    reqAddr  = {a1, a0};
    reqData  = {d1, d0};
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which requester is next in line, the write that should be on the
  // reg_file port this cycle, and the resulting register contents.
  int          mNext;
  bit          mInit;
  logic        mWe;
  logic [1:0]  mAddr;
  logic [31:0] mData;
  logic        mId;
  logic [31:0] mRegs [4];
  logic [1:0]  sawAccept;

  initial begin
    mNext = 0;
    mInit = 0;
    mWe   = 0;
    mAddr = '0;
    mData = '0;
    mId   = 0;
    for (int r = 0; r < 4; r++) mRegs[r] = '0;
  end

  // Compare process: at each falling edge the inputs are stable until the next
  // rising edge, so the expected grant and the next model state follow directly.
  always @(negedge clk) begin
    logic [1:0] expReady;
    int         winner;
    bit         allowed;
    expReady = '0;
    winner   = -1;
    if (!rst && !stall) begin
      for (int k = 0; k < NR; k++) begin
        int cand;
        cand = (mNext + k) % NR;
        if (winner < 0 && reqValid[cand]) winner = cand;
      end
      if (winner >= 0) expReady[winner] = 1'b1;
    end
    checkOutput("reqReady", 64'(reqReady), 64'(expReady));
    sawAccept = reqValid & reqReady;
    if (mInit) begin
      checkOutput("writeEn", 64'(writeEn), 64'(mWe));
      checkOutput("writeAddr", 64'(writeAddr), 64'(mAddr));
      checkOutput("writeData", 64'(writeData), 64'(mData));
      checkOutput("grantId", 64'(grantId), 64'(mId));
      if (mWe) mRegs[mAddr] = mData;
    end
    if (rst) begin
      mInit = 1;
      mNext = 0;
      mWe   = 0;
      mAddr = '0;
      mData = '0;
      mId   = 0;
    end else if (winner >= 0) begin
      mAddr = reqAddr[winner*IW +: IW];
      mData = reqData[winner*DW +: DW];
      mId   = winner[0];
      allowed = 1;
`ifdef REG_FILE_WR_ZERO_PROTECT_EN
      if (mAddr == 2'd0) allowed = 0;
`endif
      mWe   = allowed;
      mNext = (winner + 1) % NR;
    end else begin
      mWe = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  pend;
    logic [1:0]  pa [2];
    logic [31:0] pd [2];

    applyStimulus(1, 0, 2'b11, 2'd1, 32'h1111, 2'd2, 32'h2222);

    // Reset held for two cycles with both requesters valid.
    @(negedge clk);
    checkOutput("rst_ready", 64'(reqReady), 64'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("rst_ready2", 64'(reqReady), 64'h0);
    checkOutput("rst_we", 64'(writeEn), 64'h0);
    checkOutput("rst_addr", 64'(writeAddr), 64'h0);
    checkOutput("rst_data", 64'(writeData), 64'h0);
    checkOutput("rst_id", 64'(grantId), 64'h0);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    nextCycle();

    // Single request from requester 0.
    applyStimulus(0, 0, 2'b01, 2'd2, 32'h0A0A, 2'd0, 32'h0);
    @(negedge clk);
    checkOutput("single_ready", 64'(reqReady), 64'h1);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    @(negedge clk);
    checkOutput("single_we", 64'(writeEn), 64'h1);
    checkOutput("single_addr", 64'(writeAddr), 64'h2);
    checkOutput("single_data", 64'(writeData), 64'h0A0A);
    checkOutput("single_id", 64'(grantId), 64'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("single_idle_we", 64'(writeEn), 64'h0);
    checkOutput("single_reg2", 64'(mRegs[2]), 64'h0A0A);
    nextCycle();

    // Reset once more so contention starts with requester 0 first.
    applyStimulus(1, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    nextCycle();
    applyStimulus(0, 0, 2'b11, 2'd1, 32'h0505, 2'd3, 32'h0303);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("contend_ready", 64'(reqReady), (c % 2 == 0) ? 64'h1 : 64'h2);
      nextCycle();
    end

    // Stall for three cycles: the in-flight write from requester 1 still issues.
    applyStimulus(0, 1, 2'b11, 2'd1, 32'h0505, 2'd3, 32'h0303);
    @(negedge clk);
    checkOutput("stall_ready0", 64'(reqReady), 64'h0);
    checkOutput("stall_inflight_we", 64'(writeEn), 64'h1);
    checkOutput("stall_inflight_id", 64'(grantId), 64'h1);
    checkOutput("stall_inflight_data", 64'(writeData), 64'h0303);
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("stall_ready", 64'(reqReady), 64'h0);
      checkOutput("stall_we", 64'(writeEn), 64'h0);
    end
    nextCycle();
    applyStimulus(0, 0, 2'b11, 2'd1, 32'h0505, 2'd3, 32'h0303);
    @(negedge clk);
    checkOutput("release_ready", 64'(reqReady), 64'h1);
    nextCycle();

    // Same address from both: requester 1 is next in line, requester 0 follows and wins.
    applyStimulus(0, 0, 2'b11, 2'd1, 32'hAAAA0000, 2'd1, 32'hBBBB1111);
    @(negedge clk);
    checkOutput("same_first", 64'(reqReady), 64'h2);
    nextCycle();
    applyStimulus(0, 0, 2'b01, 2'd1, 32'hAAAA0000, 2'd1, 32'hBBBB1111);
    @(negedge clk);
    checkOutput("same_second", 64'(reqReady), 64'h1);
    checkOutput("same_first_data", 64'(writeData), 64'hBBBB1111);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    nextCycle();
    @(negedge clk);
    checkOutput("same_reg1", 64'(mRegs[1]), 64'hAAAA0000);
    nextCycle();

    // Write to register 0.
    applyStimulus(0, 0, 2'b01, 2'd0, 32'hFFFF, 2'd0, 32'h0);
    @(negedge clk);
    checkOutput("zero_ready", 64'(reqReady), 64'h1);
    nextCycle();
    applyStimulus(0, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    @(negedge clk);
`ifdef REG_FILE_WR_ZERO_PROTECT_EN
    checkOutput("zero_we", 64'(writeEn), 64'h0);
`else
    checkOutput("zero_we", 64'(writeEn), 64'h1);
`endif
    nextCycle();
    @(negedge clk);
`ifdef REG_FILE_WR_ZERO_PROTECT_EN
    checkOutput("zero_reg0", 64'(mRegs[0]), 64'h0);
`else
    checkOutput("zero_reg0", 64'(mRegs[0]), 64'hFFFF);
`endif
    nextCycle();

    // Randomized traffic obeying the requester rule, with occasional stalls and resets.
    pend = '0;
    for (int r = 0; r < 2; r++) begin
      pa[r] = '0;
      pd[r] = '0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic r;
      logic s;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 7) == 0);
      for (int q = 0; q < 2; q++) begin
        if (pend[q] && sawAccept[q]) pend[q] = 1'b0;
        if (!pend[q] && $urandom_range(0, 2) != 0) begin
          pend[q] = 1'b1;
          pa[q]   = 2'($urandom_range(0, 3));
          pd[q]   = $urandom;
        end
      end
      applyStimulus(r, s, pend, pa[0], pd[0], pa[1], pd[1]);
      @(negedge clk);
      nextCycle();
    end

    applyStimulus(0, 0, 2'b00, 2'd0, 32'h0, 2'd0, 32'h0);
    nextCycle();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
